// File: rtl/viterbi_ber_checker.sv
// Bit-error-rate checker for the convolutional encode / Viterbi decode link.
// Finds the decoder latency, locks to it, then counts compared bits and errors.
//
// state     | meaning
// ST_SEARCH | stepping candidate delay until LOCK_WIN consecutive matches
// ST_LOCKED | aligned at latency_o, counting bits/errors, watching the error window
module viterbi_ber_checker #(
  parameter int MAX_LAT  = 64,
  parameter int LOCK_WIN = 32,
  parameter int LOSS_THR = 8,
  parameter int CNT_W    = 32,
  localparam int LAT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ref_valid_i,
  input  logic             ref_bit_i,
  input  logic             dut_valid_i,
  input  logic             dut_bit_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic [LAT_W-1:0] latency_o,
  output logic [CNT_W-1:0] bit_ct_o,
  output logic [CNT_W-1:0] err_ct_o,
  output logic             sync_loss_o
);

  localparam int RUN_W = $clog2(LOCK_WIN + 1);
  localparam int ERR_W = $clog2(LOSS_THR + 1);

  typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [MAX_LAT-1:0] hist_q, hist_d;
  logic [LAT_W-1:0]   fill_q, fill_d;
  logic [LAT_W-1:0]   cand_q, cand_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [RUN_W-1:0]   win_left_q, win_left_d;
  logic [ERR_W-1:0]   win_err_q, win_err_d;
  logic [CNT_W-1:0]   bit_ct_q, bit_ct_d;
  logic [CNT_W-1:0]   err_ct_q, err_ct_d;
  logic               locked_q, locked_d;
  logic               sync_loss_q, sync_loss_d;

  logic [LAT_W-1:0]   cmp_dly;
  logic               exp_bit;
  logic               cmp_vld;
  logic               miss;

  // Expected bit comes from the pre-shift history at the active delay.
  always_comb begin
    cmp_dly = (state_q == ST_LOCKED) ? lat_q : cand_q;
    exp_bit = 1'b0;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (int'(cmp_dly) == k + 1) exp_bit = hist_q[k];
    end
    cmp_vld = dut_valid_i && (cmp_dly != '0) && (fill_q >= cmp_dly);
    miss    = dut_bit_i ^ exp_bit;
  end

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    cand_d      = cand_q;
    lat_d       = lat_q;
    run_d       = run_q;
    win_left_d  = win_left_q;
    win_err_d   = win_err_q;
    bit_ct_d    = bit_ct_q;
    err_ct_d    = err_ct_q;
    locked_d    = locked_q;
    sync_loss_d = 1'b0;

    if (clear_i) begin
      state_d    = ST_SEARCH;
      hist_d     = '0;
      fill_d     = '0;
      cand_d     = LAT_W'(1);
      run_d      = '0;
      win_left_d = RUN_W'(LOCK_WIN);
      win_err_d  = '0;
      bit_ct_d   = '0;
      err_ct_d   = '0;
      locked_d   = 1'b0;
    end else begin
      if (ref_valid_i) begin
        hist_d[0] = ref_bit_i;
        for (int k = 1; k < MAX_LAT; k++) hist_d[k] = hist_q[k-1];
        if (fill_q != LAT_W'(MAX_LAT)) fill_d = fill_q + LAT_W'(1);
      end

      if (cmp_vld) begin
        if (state_q == ST_SEARCH) begin
          if (miss) begin
            run_d  = '0;
            cand_d = (cand_q == LAT_W'(MAX_LAT)) ? LAT_W'(1) : cand_q + LAT_W'(1);
          end else if (run_q == RUN_W'(LOCK_WIN - 1)) begin
            state_d    = ST_LOCKED;
            locked_d   = 1'b1;
            lat_d      = cand_q;
            run_d      = '0;
            win_left_d = RUN_W'(LOCK_WIN);
            win_err_d  = '0;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end else begin
          if (bit_ct_q != '1) bit_ct_d = bit_ct_q + CNT_W'(1);
          if (miss && (err_ct_q != '1)) err_ct_d = err_ct_q + CNT_W'(1);

          // The triggering error is still counted before the loss takes effect.
          if (miss && (win_err_q == ERR_W'(LOSS_THR - 1))) begin
            state_d     = ST_SEARCH;
            locked_d    = 1'b0;
            sync_loss_d = 1'b1;
            cand_d      = LAT_W'(1);
            run_d       = '0;
            win_left_d  = RUN_W'(LOCK_WIN);
            win_err_d   = '0;
          end else if (win_left_q == RUN_W'(1)) begin
            win_left_d = RUN_W'(LOCK_WIN);
            win_err_d  = '0;
          end else begin
            win_left_d = win_left_q - RUN_W'(1);
            if (miss) win_err_d = win_err_q + ERR_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_SEARCH;
      hist_q      <= '0;
      fill_q      <= '0;
      cand_q      <= LAT_W'(1);
      lat_q       <= '0;
      run_q       <= '0;
      win_left_q  <= RUN_W'(LOCK_WIN);
      win_err_q   <= '0;
      bit_ct_q    <= '0;
      err_ct_q    <= '0;
      locked_q    <= 1'b0;
      sync_loss_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      cand_q      <= cand_d;
      lat_q       <= lat_d;
      run_q       <= run_d;
      win_left_q  <= win_left_d;
      win_err_q   <= win_err_d;
      bit_ct_q    <= bit_ct_d;
      err_ct_q    <= err_ct_d;
      locked_q    <= locked_d;
      sync_loss_q <= sync_loss_d;
    end
  end

  assign locked_o    = locked_q;
  assign latency_o   = lat_q;
  assign bit_ct_o    = bit_ct_q;
  assign err_ct_o    = err_ct_q;
  assign sync_loss_o = sync_loss_q;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Self-checking bench for viterbi_ber_checker: scenario table, directed corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_viterbi_ber_checker;

  localparam int MAX_LAT  = 64;
  localparam int LOCK_WIN = 32;
  localparam int LOSS_THR = 8;
  localparam int LAT_W    = $clog2(MAX_LAT + 1);
  localparam longint CMAX = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst, ref_valid_i, ref_bit_i, dut_valid_i, dut_bit_i, clear_i;
  logic             locked_o;
  logic [LAT_W-1:0] latency_o;
  logic [31:0]      bit_ct_o, err_ct_o;
  logic             sync_loss_o;
  logic             locked2;
  logic [4:0]       latency2;
  logic [7:0]       bit2, err2;
  logic             loss2;

  always #5 clk = ~clk;

  viterbi_ber_checker #(.MAX_LAT(MAX_LAT), .LOCK_WIN(LOCK_WIN), .LOSS_THR(LOSS_THR), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i),
    .dut_valid_i(dut_valid_i), .dut_bit_i(dut_bit_i), .clear_i(clear_i),
    .locked_o(locked_o), .latency_o(latency_o), .bit_ct_o(bit_ct_o),
    .err_ct_o(err_ct_o), .sync_loss_o(sync_loss_o)
  );

  viterbi_ber_checker #(.MAX_LAT(16), .LOCK_WIN(32), .LOSS_THR(32), .CNT_W(8)) u_sat (
    .clk(clk), .rst(rst), .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i),
    .dut_valid_i(dut_valid_i), .dut_bit_i(dut_bit_i), .clear_i(clear_i),
    .locked_o(locked2), .latency_o(latency2), .bit_ct_o(bit2),
    .err_ct_o(err2), .sync_loss_o(loss2)
  );

  int n_checks = 0;
  int n_errors = 0;
  int loss_seen = 0;
  int loss2_seen = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: history as a queue of accepted bits, newest first.
  bit     m_hist[$];
  bit     m_locked, m_loss;
  int     m_cand, m_run, m_lat, m_wct, m_werr;
  longint m_bit, m_err;

  function automatic void model_clear();
    m_hist.delete();
    m_locked = 0; m_loss = 0; m_cand = 1; m_run = 0;
    m_wct = 0; m_werr = 0; m_bit = 0; m_err = 0;
  endfunction

  function automatic void model_reset();
    model_clear();
    m_lat = 0;
  endfunction

  function automatic void model_step(bit rv, bit rb, bit dv, bit db, bit clr);
    int d;
    bit mis;
    m_loss = 0;
    if (clr) begin
      model_clear();
      return;
    end
    d = m_locked ? m_lat : m_cand;
    if (dv && d >= 1 && m_hist.size() >= d) begin
      mis = (db != m_hist[d-1]);
      if (!m_locked) begin
        if (mis) begin
          m_run = 0;
          m_cand = (m_cand == MAX_LAT) ? 1 : m_cand + 1;
        end else begin
          m_run++;
          if (m_run == LOCK_WIN) begin
            m_locked = 1; m_lat = m_cand; m_run = 0; m_wct = 0; m_werr = 0;
          end
        end
      end else begin
        if (m_bit < CMAX) m_bit++;
        if (mis && m_err < CMAX) m_err++;
        m_wct++;
        m_werr += int'(mis);
        if (m_werr >= LOSS_THR) begin
          m_locked = 0; m_loss = 1; m_cand = 1; m_run = 0; m_wct = 0; m_werr = 0;
        end else if (m_wct == LOCK_WIN) begin
          m_wct = 0; m_werr = 0;
        end
      end
    end
    if (rv) begin
      m_hist.push_front(rb);
      if (m_hist.size() > MAX_LAT) void'(m_hist.pop_back());
    end
  endfunction

  task automatic check_all();
    chk("locked", longint'(locked_o), longint'(m_locked));
    chk("latency", longint'(latency_o), longint'(m_lat));
    chk("bit_ct", longint'(bit_ct_o), m_bit);
    chk("err_ct", longint'(err_ct_o), m_err);
    chk("sync_loss", longint'(sync_loss_o), longint'(m_loss));
  endtask

  task automatic step(bit rv, bit rb, bit dv, bit db, bit clr);
    ref_valid_i = rv; ref_bit_i = rb; dut_valid_i = dv; dut_bit_i = db; clear_i = clr;
    @(posedge clk);
    model_step(rv, rb, dv, db, clr);
    #1;
    check_all();
    loss_seen  += int'(sync_loss_o);
    loss2_seen += int'(loss2);
  endtask

  logic [6:0] lfsr = 7'h7F;
  bit sent[$];

  function automatic bit prbs_next();
    bit b;
    b = lfsr[6] ^ lfsr[5];
    lfsr = {lfsr[5:0], b};
    return b;
  endfunction

  // One link cycle: dut bit is the reference delayed by d accepted samples.
  task automatic link(int d, bit rv, bit dv, bit flip, bit clr);
    bit rb, db;
    int n;
    rb = rv ? prbs_next() : 1'b0;
    n  = sent.size();
    db = 1'b0;
    if (dv) db = (n >= d) ? (sent[n-d] ^ flip) : 1'($urandom_range(0, 1));
    step(rv, rb, dv, db, clr);
    if (clr) sent.delete();
    else if (rv) sent.push_back(rb);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_locked", longint'(locked_o), 0);
    chk("rst_latency", longint'(latency_o), 0);
    chk("rst_bit_ct", longint'(bit_ct_o), 0);
    chk("rst_err_ct", longint'(err_ct_o), 0);
    chk("rst_sync_loss", longint'(sync_loss_o), 0);
    chk("rst_sat_locked", longint'(locked2), 0);
    #1 rst = 1'b1;
    model_reset();
    sent.delete();
  endtask

  task automatic wait_lock(int d, int budget, string name);
    int cnt;
    cnt = 0;
    while (!m_locked && cnt < budget) begin
      link(d, 1, sent.size() >= d, 0, 0);
      cnt++;
    end
    chk(name, longint'(locked_o), 1);
  endtask

  typedef struct {
    int delay;
    int nsamp;
    bit exp_locked;
    int exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int post;
    int d;
    vecs[0] = '{10, 1000, 1'b1, 10};
    vecs[1] = '{1, 300, 1'b1, 1};
    vecs[2] = '{37, 1000, 1'b1, 37};
    vecs[3] = '{64, 2000, 1'b1, 64};
    vecs[4] = '{65, 10000, 1'b0, 0};

    rst = 1'b1; ref_valid_i = 0; ref_bit_i = 0; dut_valid_i = 0; dut_bit_i = 0; clear_i = 0;
    #1 rst = 1'b0;
    #1;
    chk("por_locked", longint'(locked_o), 0);
    chk("por_latency", longint'(latency_o), 0);
    chk("por_bit_ct", longint'(bit_ct_o), 0);
    chk("por_err_ct", longint'(err_ct_o), 0);
    chk("por_sync_loss", longint'(sync_loss_o), 0);
    #2 rst = 1'b1;
    model_reset();

    // Scenario table: clean delayed stream, expected lock result.
    foreach (vecs[v]) begin
      do_reset();
      post = 0;
      for (int i = 0; i < vecs[v].nsamp; i++) begin
        if (m_locked && sent.size() >= vecs[v].delay) post++;
        link(vecs[v].delay, 1, sent.size() >= vecs[v].delay, 0, 0);
      end
      chk($sformatf("tbl%0d_locked", v), longint'(locked_o), longint'(vecs[v].exp_locked));
      chk($sformatf("tbl%0d_latency", v), longint'(latency_o), vecs[v].exp_lat);
      chk($sformatf("tbl%0d_err_ct", v), longint'(err_ct_o), 0);
      chk($sformatf("tbl%0d_bit_ct", v), longint'(bit_ct_o), post);
    end

    // Sparse errors: one flip every 16th sample.
    do_reset();
    wait_lock(10, 1000, "sparse_lock");
    chk("sparse_err0", longint'(err_ct_o), 0);
    loss_seen = 0;
    for (int i = 0; i < 320; i++) link(10, 1, 1, (i % 16) == 15, 0);
    chk("sparse_err", longint'(err_ct_o), 20);
    chk("sparse_locked", longint'(locked_o), 1);
    chk("sparse_noloss", loss_seen, 0);

    // Burst of 8 errors starting on a fresh window.
    begin
      int cnt;
      cnt = 0;
      while (!(m_locked && m_wct == 0) && cnt < 64) begin
        link(10, 1, 1, 0, 0);
        cnt++;
      end
      chk("burst_align", longint'(cnt < 64), 1);
    end
    for (int i = 0; i < 8; i++) begin
      link(10, 1, 1, 1, 0);
      if (i < 7) begin
        chk("burst_pre_loss", longint'(sync_loss_o), 0);
        chk("burst_pre_locked", longint'(locked_o), 1);
      end
    end
    chk("burst_loss", longint'(sync_loss_o), 1);
    chk("burst_unlocked", longint'(locked_o), 0);
    chk("burst_err", longint'(err_ct_o), 28);
    link(10, 1, 1, 0, 0);
    chk("burst_pulse_end", longint'(sync_loss_o), 0);
    chk("burst_err_hold", longint'(err_ct_o), 28);
    wait_lock(10, 1000, "relock");
    chk("relock_latency", longint'(latency_o), 10);

    // Clear in the same cycle as an erroring compare.
    for (int i = 0; i < 5; i++) link(10, 1, 1, 0, 0);
    link(10, 1, 1, 1, 1);
    chk("clr_bit_ct", longint'(bit_ct_o), 0);
    chk("clr_err_ct", longint'(err_ct_o), 0);
    chk("clr_locked", longint'(locked_o), 0);
    chk("clr_latency", longint'(latency_o), 10);
    chk("clr_sync_loss", longint'(sync_loss_o), 0);
    wait_lock(10, 1000, "clr_relock");
    chk("clr_relock_latency", longint'(latency_o), 10);

    // Reset while locked (checks inside do_reset happen before the next edge).
    for (int i = 0; i < 10; i++) link(10, 1, 1, 0, 0);
    chk("pre_rst_locked", longint'(locked_o), 1);
    do_reset();

    // Saturation on the 8-bit instance, error on every 2nd compare.
    wait_lock(10, 1000, "sat_lock_ref");
    chk("sat_locked", longint'(locked2), 1);
    chk("sat_latency", longint'(latency2), 10);
    loss2_seen = 0;
    for (int i = 0; i < 600; i++) begin
      link(10, 1, 1, (i % 2) == 0, 0);
      if (i == 99) begin
        chk("sat_bit_100", longint'(bit2), 100);
        chk("sat_err_50", longint'(err2), 50);
      end
      if (i == 299) begin
        chk("sat_bit_stick", longint'(bit2), 255);
        chk("sat_err_150", longint'(err2), 150);
      end
    end
    chk("sat_bit_final", longint'(bit2), 255);
    chk("sat_err_final", longint'(err2), 255);
    chk("sat_still_locked", longint'(locked2), 1);
    chk("sat_noloss", loss2_seen, 0);

    // Randomized traffic against the model.
    do_reset();
    d = int'($urandom_range(1, 20));
    for (int i = 0; i < 4000; i++) begin
      link(d, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6,
           $urandom_range(0, 49) == 0, $urandom_range(0, 499) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/viterbi_ber_checker.md
Name: viterbi_ber_checker

Overview:
- Receive-side bit-error-rate checker for the convolutional encode / channel / Viterbi decode link.
- Takes two streams:
  - the source bit stream presented to the encoder;
  - the decoded bit stream out of the Viterbi decoder.
- Finds the decoder latency automatically, locks to it, then counts compared bits and bit errors.
- Sits beside the tx/rx link in the top-level harness and replaces ad-hoc $display error accounting with hardware counters.

Parameters:
- MAX_LAT, 64: largest decoder latency searched, in accepted reference samples (≥1).
- LOCK_WIN, 32: consecutive matching compares required to declare lock; also the loss-of-lock window length.
- LOSS_THR, 8: errors within one LOCK_WIN window that force loss of lock (1 ≤ LOSS_THR ≤ LOCK_WIN).
- CNT_W, 32: width of the bit and error counters.

Ports:
- clk, input, 1: sole clock; all state on rising edge.
- rst, input, 1: asynchronous, active-low reset.
- ref_valid_i, input, 1: source bit accepted this cycle (same qualifier as the encoder enable).
- ref_bit_i, input, 1: source data bit.
- dut_valid_i, input, 1: decoder output bit valid this cycle.
- dut_bit_i, input, 1: decoder output bit.
- clear_i, input, 1: synchronous clear of counters and lock.
- locked_o, output, 1: aligned and counting.
- latency_o, output, $clog2(MAX_LAT+1): locked delay D; holds last value when unlocked.
- bit_ct_o, output, CNT_W: compares made while locked.
- err_ct_o, output, CNT_W: mismatches while locked.
- sync_loss_o, output, 1: one-cycle pulse when lock is lost.

Behaviour:
- **Reset (rst low)**, immediate and without a clock:
  - all outputs 0;
  - state SEARCH, candidate delay cand=1;
  - history and fill count cleared.
- **History:** shift register hist[0..MAX_LAT-1] plus fill counter saturating at MAX_LAT.
  - On ref_valid_i: hist[0]<=ref_bit_i, hist[k]<=hist[k-1], fill++.
- **Compare rule:** on dut_valid_i with delay D, expected bit = registered hist[D-1], i.e. the value before this cycle's shift.
  - Simultaneous ref_valid_i and dut_valid_i therefore compares against pre-shift history.
  - If fill < D, the compare is skipped: no counts, no state effect.
- **SEARCH state:**
  - Each valid compare at D=cand:
    - match: run++;
    - mismatch: run<=0 and cand<=cand+1, wrapping MAX_LAT→1.
  - When run reaches LOCK_WIN: go to LOCKED next cycle, latency_o<=cand, locked_o<=1.
  - Compares made during search are not counted.
- **LOCKED state:**
  - Each valid compare at D=latency_o: bit_ct_o++, err_ct_o += mismatch, win_ct++, win_err += mismatch.
  - When win_ct reaches LOCK_WIN: win_ct and win_err reset to 0.
  - If win_err would reach LOSS_THR on this compare:
    - next state SEARCH, locked_o<=0, sync_loss_o=1 for exactly one cycle;
    - cand<=1, run<=0;
    - bit_ct_o and err_ct_o hold, including the triggering error.
- **Counter saturation:** bit_ct_o and err_ct_o saturate at all-ones and never wrap. An erroring compare at bit_ct saturation still increments err_ct until it too saturates.
- **clear_i (synchronous):**
  - Effect: counters, window, run, fill and history cleared; state SEARCH, cand=1; locked_o=0.
  - latency_o is not cleared.
  - sync_loss_o is not pulsed.
  - clear_i has priority over same-cycle ref_valid_i and dut_valid_i; those samples are discarded.
- **Reset mid-operation:** identical to power-on reset; a partial window is discarded.
- **Latency beyond MAX_LAT:** never locks; cand cycles indefinitely; locked_o stays 0.
- **Outputs:** all registered; no combinational input→output paths.

Test Plan:
- **Basic lock.** Reset, PRBS7 ref stream, dut = ref delayed by 10 accepted samples, 1000 bits.
  - Required: locked_o=1, latency_o=10.
  - After the 1000 bits: err_ct_o=0 and bit_ct_o equals the dut samples after lock.
- **Sparse errors.** After lock, flip one dut bit every 16th sample for 320 samples.
  - Required: err_ct_o increments by exactly 20, locked_o stays 1, sync_loss_o never pulses.
- **Burst loss and relock.** After lock, flip 8 consecutive dut bits.
  - Required: sync_loss_o pulses for one cycle on the 8th error; err_ct_o rises by 8 then holds; locked_o=0.
  - Required: relock with latency_o=10.
- **Latency limits.** Delay=64 → locks with latency_o=64. Delay=65 → locked_o=0 for 10000 samples.
- **Clear priority.** clear_i asserted in the same cycle as dut_valid_i and an erroring bit while locked.
  - Required next cycle: bit_ct_o=0, err_ct_o=0, locked_o=0, latency_o unchanged, no sync_loss_o.
  - Required after: relock to latency_o=10.
- **Reset and saturation.**
  - rst low mid-LOCKED → all outputs 0 before the next clk edge.
  - Separately, with CNT_W=8 and 300 errored compares: err_ct_o and bit_ct_o stick at 255.
  - These compares use a sub-threshold error pattern (LOSS_THR=LOCK_WIN=32, error every 2nd bit).
